// File: rtl/ysyx_23060184_mem_stage.sv
// Memory-access stage: one single-beat AXI4-Lite load/store per instruction.
// Handles store alignment, load extension and valid/ready hand-off to MEM/WB.
module ysyx_23060184_mem_stage #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned WMASK_LENGTH   = 4,
   parameter int unsigned ROPCODE_LENGTH = 3
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      Mvalid,
   output logic                      Mready,
   input  logic                      MemReadM,
   input  logic                      MemWriteM,
   input  logic [WMASK_LENGTH-1:0]   WmaskM,
   input  logic [ROPCODE_LENGTH-1:0] RopcodeM,
   input  logic [DATA_WIDTH-1:0]     ALUResultM,
   input  logic [DATA_WIDTH-1:0]     WriteDataM,
   output logic                      Wvalid,
   input  logic                      Wready,
   output logic [DATA_WIDTH-1:0]     ReadDataM,
   output logic                      AccessFault,
   output logic                      MisalignFault,
   output logic [DATA_WIDTH-1:0]     araddr,
   output logic                      arvalid,
   input  logic                      arready,
   input  logic [DATA_WIDTH-1:0]     rdata,
   input  logic [1:0]                rresp,
   input  logic                      rvalid,
   output logic                      rready,
   output logic [DATA_WIDTH-1:0]     awaddr,
   output logic                      awvalid,
   input  logic                      awready,
   output logic [DATA_WIDTH-1:0]     wdata,
   output logic [WMASK_LENGTH-1:0]   wstrb,
   output logic                      wvalid,
   input  logic                      wready,
   input  logic [1:0]                bresp,
   input  logic                      bvalid,
   output logic                      bready
);
   localparam int unsigned OFF_W = $clog2(WMASK_LENGTH);

   typedef enum logic [2:0] {IDLE, AR, R, WR, B, DONE} stateT;

   stateT                     state;
   logic [OFF_W-1:0]          offQ;
   logic [ROPCODE_LENGTH-1:0] ropQ;
   logic [OFF_W-1:0]          off;
   logic                      halfLoad, wordLoad, readMis, writeMis, misalign;
   logic [DATA_WIDTH-1:0]     loadShift, loadExt, wordAddr;

   assign off      = ALUResultM[OFF_W-1:0];
   assign wordAddr = {ALUResultM[DATA_WIDTH-1:OFF_W], OFF_W'(0)};

   // Alignment rules: read type decides when both flags are set
   always_comb begin
      halfLoad = (RopcodeM == ROPCODE_LENGTH'(1)) || (RopcodeM == ROPCODE_LENGTH'(5));
      wordLoad = (RopcodeM == ROPCODE_LENGTH'(2));
      readMis  = (halfLoad && off[0]) || (wordLoad && (off != OFF_W'(0)));
      writeMis = ((WmaskM == WMASK_LENGTH'(3)) && off[0]) ||
                 ((WmaskM == WMASK_LENGTH'(15)) && (off != OFF_W'(0)));
      misalign = 1'b0;
      if (MemReadM)       misalign = readMis;
      else if (MemWriteM) misalign = writeMis;
   end

   // Byte-lane select and sign/zero extension of the returned word
   always_comb begin
      loadShift = rdata >> {offQ, 3'b000};
      loadExt   = loadShift;
      case (ropQ)
         ROPCODE_LENGTH'(0): loadExt = {{(DATA_WIDTH-8){loadShift[7]}}, loadShift[7:0]};
         ROPCODE_LENGTH'(1): loadExt = {{(DATA_WIDTH-16){loadShift[15]}}, loadShift[15:0]};
         ROPCODE_LENGTH'(4): loadExt = {{(DATA_WIDTH-8){1'b0}}, loadShift[7:0]};
         ROPCODE_LENGTH'(5): loadExt = {{(DATA_WIDTH-16){1'b0}}, loadShift[15:0]};
         default:            loadExt = loadShift;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         Mready        <= 1'b1;
         Wvalid        <= 1'b0;
         ReadDataM     <= '0;
         AccessFault   <= 1'b0;
         MisalignFault <= 1'b0;
         araddr        <= '0;
         arvalid       <= 1'b0;
         rready        <= 1'b0;
         awaddr        <= '0;
         awvalid       <= 1'b0;
         wdata         <= '0;
         wstrb         <= '0;
         wvalid        <= 1'b0;
         bready        <= 1'b0;
         offQ          <= '0;
         ropQ          <= '0;
      end else begin
         case (state)
            IDLE: if (Mvalid) begin
               Mready        <= 1'b0;
               offQ          <= off;
               ropQ          <= RopcodeM;
               ReadDataM     <= '0;
               AccessFault   <= 1'b0;
               MisalignFault <= misalign;
               if (misalign || (!MemReadM && !MemWriteM)) begin
                  state  <= DONE;
                  Wvalid <= 1'b1;
               end else if (MemReadM) begin
                  state   <= AR;
                  araddr  <= wordAddr;
                  arvalid <= 1'b1;
               end else begin
                  state   <= WR;
                  awaddr  <= wordAddr;
                  awvalid <= 1'b1;
                  wdata   <= WriteDataM << {off, 3'b000};
                  wstrb   <= WmaskM << off;
                  wvalid  <= 1'b1;
               end
            end
            AR: if (arready) begin
               arvalid <= 1'b0;
               rready  <= 1'b1;
               state   <= R;
            end
            R: if (rvalid) begin
               rready      <= 1'b0;
               ReadDataM   <= loadExt;
               AccessFault <= (rresp != 2'b00);
               Wvalid      <= 1'b1;
               state       <= DONE;
            end
            WR: begin
               // Address and data channels complete independently
               if (awready) awvalid <= 1'b0;
               if (wready)  wvalid  <= 1'b0;
               if ((!awvalid || awready) && (!wvalid || wready)) begin
                  bready <= 1'b1;
                  state  <= B;
               end
            end
            B: if (bvalid) begin
               bready      <= 1'b0;
               AccessFault <= (bresp != 2'b00);
               Wvalid      <= 1'b1;
               state       <= DONE;
            end
            DONE: if (Wready) begin
               Wvalid <= 1'b0;
               Mready <= 1'b1;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ysyx_23060184_mem_stage.sv
// Bench for ysyx_23060184_mem_stage: AXI4-Lite slave model, per-cycle protocol/result
// checks against a transaction-level model, directed corner cases and random traffic.
module tb_ysyx_23060184_mem_stage;
   logic        clk = 1'b0, reset = 1'b1;
   logic        Mvalid = 0, Mready, MemReadM = 0, MemWriteM = 0;
   logic [3:0]  WmaskM = 0;
   logic [2:0]  RopcodeM = 0;
   logic [31:0] ALUResultM = 0, WriteDataM = 0;
   logic        Wvalid, Wready = 0, AccessFault, MisalignFault;
   logic [31:0] ReadDataM, araddr, awaddr, wdata, rdata = 0;
   logic        arvalid, arready = 0, rvalid = 0, rready;
   logic        awvalid, awready = 0, wvalid, wready = 0, bvalid = 0, bready;
   logic [3:0]  wstrb;
   logic [1:0]  rresp = 0, bresp = 0;

   ysyx_23060184_mem_stage dut (
      .clk(clk), .reset(reset), .Mvalid(Mvalid), .Mready(Mready),
      .MemReadM(MemReadM), .MemWriteM(MemWriteM), .WmaskM(WmaskM), .RopcodeM(RopcodeM),
      .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .Wvalid(Wvalid), .Wready(Wready),
      .ReadDataM(ReadDataM), .AccessFault(AccessFault), .MisalignFault(MisalignFault),
      .araddr(araddr), .arvalid(arvalid), .arready(arready), .rdata(rdata), .rresp(rresp),
      .rvalid(rvalid), .rready(rready), .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready), .bresp(bresp),
      .bvalid(bvalid), .bready(bready)
   );

   always #5 clk = ~clk;

   int errors = 0, checks = 0;
   int mode = 1;  // 0 random, 1 zero-wait, 2 arready held low, 3 wready two cycles after aw
   int cyc = 0, awHsCyc = 0;
   int arCnt = 0, rCnt = 0, awCnt = 0, wCnt = 0, bCnt = 0;
   int arBase = 0, rBase = 0, awBase = 0, wBase = 0, bBase = 0;
   bit monOn = 0, inFlight = 0, arRaised = 0, awRaised = 0, wRaised = 0;
   bit expRead, expWrite, expMis, expAF;
   logic [31:0] expAddr, expData, expWdata, slvRdata;
   logic [3:0]  expWstrb;
   logic [1:0]  slvResp;
   logic [31:0] lastAraddr, lastWdata, capData;
   logic [3:0]  lastWstrb;
   logic        capAF, capMF;
   int          lat;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Transaction-level model of the load result
   function automatic logic [31:0] modelLoad(input logic [31:0] rd, input logic [1:0] off,
                                             input logic [2:0] rop);
      logic [31:0] s, v;
      s = rd >> (8 * off);
      case (rop)
         3'd0: begin v = s & 32'hFF;   if (v >= 32'd128)   v = v + 32'hFFFF_FF00; end
         3'd1: begin v = s & 32'hFFFF; if (v >= 32'd32768) v = v + 32'hFFFF_0000; end
         3'd4: v = s & 32'hFF;
         3'd5: v = s & 32'hFFFF;
         default: v = s;
      endcase
      return v;
   endfunction

   // Slave bookkeeping of handshakes that complete at this edge
   always @(posedge clk) begin
      if (arvalid && arready) arCnt++;
      if (rvalid && rready)   rCnt++;
      if (awvalid && awready) begin awCnt++; awHsCyc = cyc; end
      if (wvalid && wready)   wCnt++;
      if (bvalid && bready)   bCnt++;
      cyc++;
   end

   // Slave drive: readies per mode, responses held until accepted
   always @(negedge clk) begin
      case (mode)
         1: begin arready = 1; awready = 1; wready = 1; end
         2: begin arready = 0; awready = 0; wready = 0; end
         3: begin arready = 1; awready = 1; wready = (awCnt > awBase) && (cyc >= awHsCyc + 2); end
         default: begin
            arready = 1'($urandom_range(1, 0));
            awready = 1'($urandom_range(1, 0));
            wready  = 1'($urandom_range(1, 0));
         end
      endcase
      if (arCnt > rCnt) rvalid = rvalid | (mode != 0) | 1'($urandom_range(1, 0));
      else              rvalid = 0;
      rdata = rvalid ? slvRdata : $urandom;
      rresp = slvResp;
      if (awCnt > bCnt && wCnt > bCnt) bvalid = bvalid | (mode != 0) | 1'($urandom_range(1, 0));
      else                             bvalid = 0;
      bresp = slvResp;
   end

   // Per-cycle compare against the model and AXI ordering rules
   always @(negedge clk) if (monOn && !reset) begin
      if (inFlight) chk("mready_busy", 32'(Mready), 32'd0);
      if (arvalid) begin
         lastAraddr = araddr; arRaised = 1;
         chk("ar_allowed", 32'(expRead && arCnt == arBase), 32'd1);
         chk("araddr", araddr, expAddr & 32'hFFFF_FFFC);
      end else if (arRaised && arCnt == arBase) chk("arvalid_held", 32'(arvalid), 32'd1);
      if (awvalid) begin
         awRaised = 1;
         chk("aw_allowed", 32'(expWrite && awCnt == awBase), 32'd1);
         chk("awaddr", awaddr, expAddr & 32'hFFFF_FFFC);
      end else if (awRaised && awCnt == awBase) chk("awvalid_held", 32'(awvalid), 32'd1);
      if (wvalid) begin
         lastWdata = wdata; lastWstrb = wstrb; wRaised = 1;
         chk("w_allowed", 32'(expWrite && wCnt == wBase), 32'd1);
         chk("wdata", wdata, expWdata);
         chk("wstrb", 32'(wstrb), 32'(expWstrb));
      end else if (wRaised && wCnt == wBase) chk("wvalid_held", 32'(wvalid), 32'd1);
      if (rready) chk("rready_ok", 32'(expRead && arCnt > arBase && rCnt == rBase), 32'd1);
      if (bready) chk("bready_ok", 32'(expWrite && awCnt > awBase && wCnt > wBase && bCnt == bBase), 32'd1);
      if (Wvalid) begin
         chk("ReadDataM", ReadDataM, expData);
         chk("AccessFault", 32'(AccessFault), 32'(expAF));
         chk("MisalignFault", 32'(MisalignFault), 32'(expMis));
         chk("ar_count", 32'(arCnt - arBase), 32'(expRead));
         chk("aw_count", 32'(awCnt - awBase), 32'(expWrite));
         chk("b_count", 32'(bCnt - bBase), 32'(expWrite));
      end
   end

   task automatic runTxn(input bit rd, input bit wr, input logic [3:0] mask, input logic [2:0] rop,
                         input logic [31:0] addr, input logic [31:0] data, input logic [31:0] rdat,
                         input logic [1:0] resp, input int wrDelay);
      logic [1:0] off;
      bit found;
      off = addr[1:0];
      expMis = 0;
      if (rd)      expMis = ((rop == 3'd1 || rop == 3'd5) && addr[0]) || (rop == 3'd2 && off != 0);
      else if (wr) expMis = (mask == 4'b0011 && addr[0]) || (mask == 4'b1111 && off != 0);
      expRead  = rd && !expMis;
      expWrite = wr && !rd && !expMis;
      expAddr  = addr;
      expData  = expRead ? modelLoad(rdat, off, rop) : 32'd0;
      expAF    = (expRead || expWrite) && resp != 2'b00;
      expWdata = data << (8 * off);
      expWstrb = 4'((32'(mask) << off) & 32'hF);
      slvRdata = rdat; slvResp = resp;
      arBase = arCnt; rBase = rCnt; awBase = awCnt; wBase = wCnt; bBase = bCnt;
      arRaised = 0; awRaised = 0; wRaised = 0;
      @(negedge clk);
      chk("mready_idle", 32'(Mready), 32'd1);
      Mvalid = 1; MemReadM = rd; MemWriteM = wr; WmaskM = mask; RopcodeM = rop;
      ALUResultM = addr; WriteDataM = data;
      @(posedge clk); #1;
      inFlight = 1;
      Mvalid = 0; MemReadM = 1'($urandom); MemWriteM = 1'($urandom); WmaskM = 4'($urandom);
      RopcodeM = 3'($urandom); ALUResultM = $urandom; WriteDataM = $urandom;
      found = 0; lat = 0;
      for (int i = 1; i <= 200 && !found; i++) begin
         @(negedge clk);
         if (Wvalid) begin found = 1; lat = i; end
      end
      if (!found) chk("wvalid_timeout", 32'(Wvalid), 32'd1);
      capData = ReadDataM; capAF = AccessFault; capMF = MisalignFault;
      for (int i = 0; i < wrDelay; i++) begin
         @(negedge clk);
         chk("wvalid_hold", 32'(Wvalid), 32'd1);
      end
      Wready = 1;
      @(posedge clk); #1;
      Wready = 0; inFlight = 0;
      @(negedge clk);
      chk("mready_after", 32'(Mready), 32'd1);
      chk("wvalid_drop", 32'(Wvalid), 32'd0);
   endtask

   logic [2:0] ropTab[7] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd7};
   logic [3:0] maskTab[3] = '{4'b0001, 4'b0011, 4'b1111};

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_mready", 32'(Mready), 32'd1);
      chk("rst_wvalid", 32'(Wvalid), 32'd0);
      chk("rst_arvalid", 32'(arvalid), 32'd0);
      chk("rst_awvalid", 32'(awvalid || wvalid || rready || bready), 32'd0);
      chk("rst_readdata", ReadDataM, 32'd0);
      chk("rst_wstrb", 32'(wstrb), 32'd0);
      reset = 0;
      monOn = 1;

      // Zero-wait lw
      mode = 1;
      runTxn(1, 0, 4'hF, 3'd2, 32'h8000_0004, 0, 32'hDEAD_BEEF, 2'b00, 0);
      chk("lw_latency", 32'(lat), 32'd3);
      chk("lw_araddr", lastAraddr, 32'h8000_0004);
      chk("lw_data", capData, 32'hDEAD_BEEF);
      chk("lw_af", 32'(capAF), 32'd0);

      // lb / lbu from the top byte
      runTxn(1, 0, 4'h1, 3'd0, 32'h8000_0003, 0, 32'h80FF_1234, 2'b00, 0);
      chk("lb_data", capData, 32'hFFFF_FF80);
      runTxn(1, 0, 4'h1, 3'd4, 32'h8000_0003, 0, 32'h80FF_1234, 2'b00, 0);
      chk("lbu_data", capData, 32'h0000_0080);

      // sh with awready two cycles ahead of wready
      mode = 3;
      runTxn(0, 1, 4'b0011, 3'd0, 32'h8000_0002, 32'h0000_ABCD, 0, 2'b00, 0);
      chk("sh_wstrb", 32'(lastWstrb), 32'h0000_000C);
      chk("sh_wdata", lastWdata, 32'hABCD_0000);
      chk("sh_latency", 32'(lat), 32'd5);

      // Misaligned lw skips the bus
      mode = 1;
      runTxn(1, 0, 4'hF, 3'd2, 32'h8000_0001, 0, 32'h1111_1111, 2'b00, 0);
      chk("mis_latency", 32'(lat), 32'd1);
      chk("mis_flag", 32'(capMF), 32'd1);
      chk("mis_data", capData, 32'd0);

      // sw with error response and stalled MEM/WB
      runTxn(0, 1, 4'hF, 3'd2, 32'h8000_0008, 32'h1234_5678, 0, 2'b10, 3);
      chk("sw_latency", 32'(lat), 32'd3);
      chk("sw_af", 32'(capAF), 32'd1);

      // Non-memory instruction
      runTxn(0, 0, 4'h0, 3'd0, 32'h0000_0123, 0, 0, 2'b00, 0);
      chk("nop_latency", 32'(lat), 32'd1);

      // Reset while arvalid is pending
      monOn = 0; mode = 2;
      @(negedge clk);
      Mvalid = 1; MemReadM = 1; MemWriteM = 0; RopcodeM = 3'd2; ALUResultM = 32'h8000_0010;
      @(posedge clk); #1 Mvalid = 0;
      @(negedge clk);
      chk("ar_pending", 32'(arvalid), 32'd1);
      #2 reset = 1;
      #1;
      chk("rst_ar_arvalid", 32'(arvalid), 32'd0);
      chk("rst_ar_wvalid", 32'(Wvalid), 32'd0);
      chk("rst_ar_mready", 32'(Mready), 32'd1);
      @(negedge clk); reset = 0; mode = 1; monOn = 1;
      runTxn(1, 0, 4'hF, 3'd2, 32'h8000_0010, 0, 32'h1234_5678, 2'b00, 0);
      chk("post_rst_latency", 32'(lat), 32'd3);
      chk("post_rst_data", capData, 32'h1234_5678);

      // Random traffic against a random-latency slave
      mode = 0;
      for (int n = 0; n < 80; n++) begin
         runTxn(1'($urandom), 1'($urandom), maskTab[$urandom_range(2, 0)], ropTab[$urandom_range(6, 0)],
                32'h8000_0000 | ($urandom & 32'hFFF), $urandom, $urandom,
                ($urandom_range(3, 0) == 0) ? 2'($urandom_range(3, 1)) : 2'b00,
                $urandom_range(2, 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
